onehot_mask_builder: RTL and testbench



---
 rtl/onehot_mask_builder_if.sv | 35 +++
 rtl/onehot_mask_builder.sv | 106 ++++++++++
 tb/tb_onehot_mask_builder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/onehot_mask_builder_if.sv
// Index-in / mask-out handshake bundle for onehot_mask_builder.
// out_dup exists only when ONEHOT_MASK_DUP_DETECT_EN is defined.
interface onehot_mask_builder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH),
  parameter int unsigned CNT_W = IDX_W + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mask;
  logic [CNT_W-1:0] out_count;
`ifdef ONEHOT_MASK_DUP_DETECT_EN
  logic             out_dup;
`endif

  modport master (
    output in_valid, in_idx, in_last, out_ready,
`ifdef ONEHOT_MASK_DUP_DETECT_EN
    input  out_dup,
`endif
    input  in_ready, out_valid, out_mask, out_count
  );

  modport slave (
    input  in_valid, in_idx, in_last, out_ready,
`ifdef ONEHOT_MASK_DUP_DETECT_EN
    output out_dup,
`endif
    output in_ready, out_valid, out_mask, out_count
  );
endinterface

// File: rtl/onehot_mask_builder.sv
// Packs a stream of bit indices into a multi-hot mask, emitted on the last beat.
// Optional duplicate-index flag enabled by defining ONEHOT_MASK_DUP_DETECT_EN.
module onehot_mask_builder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH),
  parameter int unsigned CNT_W = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  onehot_mask_builder_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] mask_q, mask_d, onehot;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             beat, taken;
`ifdef ONEHOT_MASK_DUP_DETECT_EN
  logic             dup_q, dup_d, hit;
`endif

  assign beat     = bus.in_valid && bus.in_ready;
  assign taken    = bus.out_valid && bus.out_ready;
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

  // Out-of-range indices decode to all zeros.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      onehot[i] = (bus.in_idx == IDX_W'(i));
    end
  end

`ifdef ONEHOT_MASK_DUP_DETECT_EN
  assign hit = |(mask_q & onehot);
`endif

  always_comb begin
    state_d = state;
    mask_d  = mask_q;
    count_d = count_q;
`ifdef ONEHOT_MASK_DUP_DETECT_EN
    dup_d   = dup_q;
`endif
    unique case (state)
      ACCUM: begin
        if (beat) begin
          mask_d  = mask_q | onehot;
          count_d = count_inc;
`ifdef ONEHOT_MASK_DUP_DETECT_EN
          dup_d   = dup_q | hit;
`endif
          if (bus.in_last) state_d = EMIT;
        end
      end
      EMIT: begin
        // A beat here implies the mask is taken; it seeds the next mask.
        if (taken) begin
          if (beat) begin
            mask_d  = onehot;
            count_d = CNT_W'(1);
            state_d = bus.in_last ? EMIT : ACCUM;
          end else begin
            mask_d  = '0;
            count_d = '0;
            state_d = ACCUM;
          end
`ifdef ONEHOT_MASK_DUP_DETECT_EN
          dup_d = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACCUM;
      mask_q  <= '0;
      count_q <= '0;
`ifdef ONEHOT_MASK_DUP_DETECT_EN
      dup_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
`ifdef ONEHOT_MASK_DUP_DETECT_EN
      dup_q   <= dup_d;
`endif
    end
  end

  assign bus.in_ready  = (state == ACCUM) || bus.out_ready;
  assign bus.out_valid = (state == EMIT);
  assign bus.out_mask  = mask_q;
  assign bus.out_count = count_q;
`ifdef ONEHOT_MASK_DUP_DETECT_EN
  assign bus.out_dup   = dup_q;
`endif

endmodule

// File: tb/tb_onehot_mask_builder.sv
// Directed bench for onehot_mask_builder with a scoreboard of expected masks.
module tb_onehot_mask_builder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  onehot_mask_builder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  onehot_mask_builder #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: {dup, count, mask}
  logic [12:0] sb_q[$];
  logic [7:0]  mdl_mask;
  logic [3:0]  mdl_cnt;
  logic        mdl_dup;

  function automatic logic obs_dup();
`ifdef ONEHOT_MASK_DUP_DETECT_EN
    return bus.out_dup;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every handshake on the output side pops one expected mask.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_output", {19'd0, obs_dup(), bus.out_count, bus.out_mask}, 32'hFFFF_FFFF);
      end else begin
        logic [12:0] e;
        e = sb_q.pop_front();
        chk("sb_mask", 32'(bus.out_mask), 32'(e[7:0]));
        chk("sb_count", 32'(bus.out_count), 32'(e[11:8]));
        chk("sb_dup", 32'(obs_dup()), 32'(e[12]));
      end
    end
  end

  task automatic model_clear();
    mdl_mask = '0;
    mdl_cnt  = '0;
    mdl_dup  = 1'b0;
  endtask

  // Drives one beat and returns #1 after the accepting edge; in_valid stays high.
  task automatic beat(input logic [2:0] idx, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_idx   = idx;
    bus.in_last  = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $error("FAIL beat_timeout observed=in_ready_low expected=in_ready_high");
        break;
      end
    end
`ifdef ONEHOT_MASK_DUP_DETECT_EN
    mdl_dup = mdl_dup | mdl_mask[idx];
`endif
    mdl_mask = mdl_mask | (8'd1 << idx);
    mdl_cnt  = (mdl_cnt == 4'hF) ? mdl_cnt : mdl_cnt + 4'd1;
    if (last) begin
      sb_q.push_back({mdl_dup, mdl_cnt, mdl_mask});
      model_clear();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    model_clear();
    repeat (2) cycle();
    reset = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mask", 32'(bus.out_mask), 32'd0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_dup", 32'(obs_dup()), 32'd0);

    // Basic three-beat mask.
    beat(3'd0, 1'b0);
    beat(3'd3, 1'b0);
    beat(3'd7, 1'b1);
    idle_in();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_mask", 32'(bus.out_mask), 32'h89);
    chk("t1_count", 32'(bus.out_count), 32'd3);
    cycle();
    chk("t1_valid_after", 32'(bus.out_valid), 32'd0);
    chk("t1_mask_after", 32'(bus.out_mask), 32'd0);

    // Backpressure: mask held, in_ready low.
    bus.out_ready = 1'b0;
    beat(3'd5, 1'b1);
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_hold_mask", 32'(bus.out_mask), 32'h20);
      chk("t2_hold_count", 32'(bus.out_count), 32'd1);
      chk("t2_hold_in_ready", 32'(bus.in_ready), 32'd0);
      cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t2_in_ready_release", 32'(bus.in_ready), 32'd1);
    cycle();
    chk("t2_valid_after", 32'(bus.out_valid), 32'd0);

    // Back-to-back single-beat masks, no bubbles.
    beat(3'd1, 1'b1);
    chk("t3_mask0", 32'(bus.out_mask), 32'h02);
    chk("t3_valid0", 32'(bus.out_valid), 32'd1);
    beat(3'd2, 1'b1);
    chk("t3_mask1", 32'(bus.out_mask), 32'h04);
    chk("t3_valid1", 32'(bus.out_valid), 32'd1);
    beat(3'd4, 1'b1);
    idle_in();
    chk("t3_mask2", 32'(bus.out_mask), 32'h10);
    chk("t3_valid2", 32'(bus.out_valid), 32'd1);
    cycle();
    chk("t3_valid_after", 32'(bus.out_valid), 32'd0);

    // Duplicates.
    beat(3'd2, 1'b0);
    beat(3'd2, 1'b0);
    beat(3'd2, 1'b1);
    idle_in();
    chk("t4_mask", 32'(bus.out_mask), 32'h04);
    chk("t4_count", 32'(bus.out_count), 32'd3);
`ifdef ONEHOT_MASK_DUP_DETECT_EN
    chk("t4_dup", 32'(bus.out_dup), 32'd1);
`endif
    cycle();
    beat(3'd6, 1'b1);
    idle_in();
    chk("t4_mask_single", 32'(bus.out_mask), 32'h40);
    chk("t4_dup_single", 32'(obs_dup()), 32'd0);
    cycle();

    // Count saturation over 16 beats.
    for (int i = 0; i < 16; i++) beat(3'(i % 8), (i == 15));
    idle_in();
    chk("t5_mask", 32'(bus.out_mask), 32'hFF);
    chk("t5_count", 32'(bus.out_count), 32'd15);
    cycle();

    // Reset discards a partial mask.
    beat(3'd1, 1'b0);
    beat(3'd4, 1'b0);
    idle_in();
    chk("t6_partial_mask", 32'(bus.out_mask), 32'h12);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    model_clear();
    chk("t6_rst_mask", 32'(bus.out_mask), 32'd0);
    chk("t6_rst_count", 32'(bus.out_count), 32'd0);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    beat(3'd6, 1'b1);
    idle_in();
    chk("t6_mask", 32'(bus.out_mask), 32'h40);
    chk("t6_count", 32'(bus.out_count), 32'd1);

    repeat (3) cycle();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
